// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: GF(2^8) helpers, FSM states and column indexing.
package aes_pkg;

    localparam int unsigned STATE_W  = 128;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; the constant operand never exceeds 4 bits here.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Column 0 occupies the most significant 32 bits of the state.
    function automatic logic [6:0] col_lsb(input logic [1:0] c);
        return {~c, 5'b00000};
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in the top byte).
module mix_single_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    input  logic             inv_i,
    output logic [COL_W-1:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [COL_W-1:0] fwd_col, inv_col;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign fwd_col = {
        gf_mul(a0, 4'h2) ^ gf_mul(a1, 4'h3) ^ a2 ^ a3,
        a0 ^ gf_mul(a1, 4'h2) ^ gf_mul(a2, 4'h3) ^ a3,
        a0 ^ a1 ^ gf_mul(a2, 4'h2) ^ gf_mul(a3, 4'h3),
        gf_mul(a0, 4'h3) ^ a1 ^ a2 ^ gf_mul(a3, 4'h2)
    };

    assign inv_col = {
        gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
        gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
        gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
        gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)
    };

    assign col_o = inv_i ? inv_col : fwd_col;

endmodule

// File: rtl/mix_columns_engine.sv
// Handshaked MixColumns/InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock,
// with a bypass mode that keeps identical timing for the final round.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic               inv,
    input  logic               bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    localparam int unsigned NGROUPS = NUM_COLS / COLS_PER_CYCLE;
    localparam int unsigned CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_e             state_q;
    logic [STATE_W-1:0] work_q, work_d;
    logic [STATE_W-1:0] state_out_q;
    logic [CW-1:0]      col_q;
    logic               inv_q, byp_q;
    logic               out_valid_q, busy_q;
    logic               accept;

    logic [1:0]       cidx    [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

    for (genvar k = 0; k < int'(COLS_PER_CYCLE); k++) begin : g_col
        assign cidx[k]   = 2'(32'(col_q) * COLS_PER_CYCLE + 32'(k));
        assign col_in[k] = work_q[col_lsb(cidx[k]) +: COL_W];

        mix_single_column u_mix (
            .col_i (col_in[k]),
            .inv_i (inv_q),
            .col_o (col_out[k])
        );
    end

    // In-place write-back of the active column group; bypass keeps the original bytes.
    always_comb begin
        work_d = work_q;
        for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
            work_d[col_lsb(cidx[k]) +: COL_W] = byp_q ? col_in[k] : col_out[k];
        end
    end

    assign accept   = in_valid && in_ready;
    assign in_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            state_out_q <= '0;
            col_q       <= '0;
            inv_q       <= 1'b0;
            byp_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            state_q     <= ST_BUSY;
            work_q      <= state_in;
            inv_q       <= inv;
            byp_q       <= bypass;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                ST_BUSY: begin
                    work_q <= work_d;
                    col_q  <= col_q + CW'(1);
                    if (col_q == CW'(NGROUPS - 1)) begin
                        state_q     <= ST_DONE;
                        state_out_q <= work_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state_out = state_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
